// File: rtl/alu_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// alu_sequencer_pkg
//   Definitions shared by the ALU sequencer and the ALU it drives:
//   - DATA_W       : register / operand width
//   - OP_*         : 4-bit ALU function codes (identical to the ALU funct field)
//   - state_t      : sequencer FSM state encoding
//   - instr_t      : latched instruction fields that do not depend on NREG
//   - is_supported_op() : true for every function code the sequencer issues
// ---------------------------------------------------------------------------
package alu_sequencer_pkg;

  localparam int unsigned DATA_W = 8;

  localparam logic [3:0] OP_XOR = 4'b0001;
  localparam logic [3:0] OP_OR  = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_ADD = 4'b0101;
  localparam logic [3:0] OP_CMP = 4'b0110;
  localparam logic [3:0] OP_SHR = 4'b0111;
  localparam logic [3:0] OP_SH  = 4'b1010;
  localparam logic [3:0] OP_SHL = 4'b1110;

  // Explicit 2-bit encoding keeps the state values identical to the
  // legacy localparam assignment.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0]        op;
    logic              imm_sel;
    logic [DATA_W-1:0] imm;
  } instr_t;

  function automatic logic is_supported_op(input logic [3:0] code);
    case (code)
      OP_ADD, OP_SUB, OP_SHL, OP_SHR, OP_XOR,
      OP_AND, OP_OR, OP_CMP, OP_SH: return 1'b1;
      default:                      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_sequencer_regfile.sv
// ---------------------------------------------------------------------------
// regfile
//   NREG x DATA_W register file.
//   Ports:
//     clk, reset         : clock, asynchronous active-high reset (clears all)
//     we, waddr, wdata   : synchronous write port
//     raddr_a / rdata_a  : combinational read port A
//     raddr_b / rdata_b  : combinational read port B
//     dbg_addr / dbg_data: combinational debug read port
// ---------------------------------------------------------------------------
module regfile
  import alu_sequencer_pkg::*;
#(
  parameter  int unsigned NREG = 8,
  localparam int unsigned AW   = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [AW-1:0]     raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] mem [NREG];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a  = mem[raddr_a];
  assign rdata_b  = mem[raddr_b];
  assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
//   Three-state (IDLE -> ISSUE -> CAPTURE) sequencer that accepts one
//   register/immediate instruction, drives an external registered ALU for a
//   single cycle and writes the ALU result (or the compare flag) back.
//   Ports:
//     clk, reset                 : clock, asynchronous active-high reset
//     instr_valid / instr_ready  : instruction handshake (ready only in IDLE)
//     op, rd, rs, imm_sel, imm   : instruction fields
//     alu_en, alu_funct,
//     alu_x, alu_y               : ALU request, non-zero only in ISSUE
//     alu_result, alu_cmp        : registered ALU outputs, consumed in CAPTURE
//     done                       : retirement pulse (CAPTURE, or ISSUE for a bad op)
//     err                        : retirement pulse for an unsupported op
//     flag                       : compare flag register
//     dbg_addr / dbg_data        : combinational register read-back
// ---------------------------------------------------------------------------
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter  int unsigned NREG = 8,
  localparam int unsigned AW   = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [3:0]        op,
  input  logic [AW-1:0]     rd,
  input  logic [AW-1:0]     rs,
  input  logic              imm_sel,
  input  logic [DATA_W-1:0] imm,
  output logic              alu_en,
  output logic [3:0]        alu_funct,
  output logic [DATA_W-1:0] alu_x,
  output logic [DATA_W-1:0] alu_y,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_cmp,
  output logic              done,
  output logic              err,
  output logic              flag,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  state_t            state_q;
  state_t            state_d;
  instr_t            instr_q;
  logic [AW-1:0]     rd_q;
  logic [AW-1:0]     rs_q;
  logic              accept;
  logic              supported;
  logic              reg_we;
  logic [DATA_W-1:0] rdata_a;
  logic [DATA_W-1:0] rdata_b;

  assign instr_ready = (state_q == IDLE);
  assign accept      = instr_valid && instr_ready;
  assign supported   = is_supported_op(instr_q.op);

  regfile #(
    .NREG (NREG)
  ) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .we       (reg_we),
    .waddr    (rd_q),
    .wdata    (alu_result),
    .raddr_a  (rd_q),
    .rdata_a  (rdata_a),
    .raddr_b  (rs_q),
    .rdata_b  (rdata_b),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   state_d = supported ? CAPTURE : IDLE;
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      instr_q <= '0;
      rd_q    <= '0;
      rs_q    <= '0;
      flag    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        instr_q <= '{op: op, imm_sel: imm_sel, imm: imm};
        rd_q    <= rd;
        rs_q    <= rs;
      end
      if (state_q == CAPTURE && instr_q.op == OP_CMP) begin
        flag <= alu_cmp;
      end
    end
  end

  // Operands come straight from the register file in ISSUE, so rd==rs sees
  // the pre-write value on both ports. Everything is gated by state, which
  // makes reset clear these outputs immediately.
  always_comb begin
    alu_en    = 1'b0;
    alu_funct = '0;
    alu_x     = '0;
    alu_y     = '0;
    done      = 1'b0;
    err       = 1'b0;
    reg_we    = 1'b0;
    case (state_q)
      ISSUE: begin
        if (supported) begin
          alu_en    = 1'b1;
          alu_funct = instr_q.op;
          alu_x     = rdata_a;
          alu_y     = instr_q.imm_sel ? instr_q.imm : rdata_b;
        end else begin
          done = 1'b1;
          err  = 1'b1;
        end
      end
      CAPTURE: begin
        done   = 1'b1;
        reg_we = (instr_q.op != OP_CMP);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_sequencer
//   Directed bench for alu_sequencer with a small registered ALU model.
// ---------------------------------------------------------------------------
module tb_alu_sequencer;

  localparam int unsigned NREG = 8;
  localparam int unsigned AW   = 3;

  localparam logic [3:0] ADD = 4'b0101;
  localparam logic [3:0] SUB = 4'b0100;
  localparam logic [3:0] SHL = 4'b1110;
  localparam logic [3:0] SHR = 4'b0111;
  localparam logic [3:0] XOR = 4'b0001;
  localparam logic [3:0] AND = 4'b0011;
  localparam logic [3:0] OR  = 4'b0010;
  localparam logic [3:0] CMP = 4'b0110;
  localparam logic [3:0] BAD = 4'b1111;

  logic          clk = 1'b0;
  logic          reset;
  logic          instr_valid;
  logic          instr_ready;
  logic [3:0]    op;
  logic [AW-1:0] rd;
  logic [AW-1:0] rs;
  logic          imm_sel;
  logic [7:0]    imm;
  logic          alu_en;
  logic [3:0]    alu_funct;
  logic [7:0]    alu_x;
  logic [7:0]    alu_y;
  logic [7:0]    alu_result = 8'h00;
  logic          alu_cmp = 1'b0;
  logic          done;
  logic          err;
  logic          flag;
  logic [AW-1:0] dbg_addr;
  logic [7:0]    dbg_data;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int en_count = 0;
  int done_count = 0;
  int hs_count = 0;
  int done_cyc[$];
  int en0, d0, hs0, n;

  alu_sequencer #(.NREG(NREG)) dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .op          (op),
    .rd          (rd),
    .rs          (rs),
    .imm_sel     (imm_sel),
    .imm         (imm),
    .alu_en      (alu_en),
    .alu_funct   (alu_funct),
    .alu_x       (alu_x),
    .alu_y       (alu_y),
    .alu_result  (alu_result),
    .alu_cmp     (alu_cmp),
    .done        (done),
    .err         (err),
    .flag        (flag),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  always #5 clk = ~clk;

  // Registered ALU model
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (alu_en) begin
      case (alu_funct)
        ADD:     alu_result <= alu_x + alu_y;
        SUB:     alu_result <= alu_x - alu_y;
        SHL:     alu_result <= alu_x << alu_y[2:0];
        SHR:     alu_result <= alu_x >> alu_y[2:0];
        XOR:     alu_result <= alu_x ^ alu_y;
        AND:     alu_result <= alu_x & alu_y;
        OR:      alu_result <= alu_x | alu_y;
        default: alu_result <= alu_x;
      endcase
      alu_cmp <= (alu_x == alu_y);
    end
  end

  always @(negedge clk) begin
    if (alu_en) en_count++;
    if (done) begin
      done_count++;
      done_cyc.push_back(cyc);
    end
    if (instr_valid && instr_ready) hs_count++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reg(input string tag, input logic [AW-1:0] a, input logic [7:0] exp);
    dbg_addr = a;
    #1;
    check(tag, {24'h0, dbg_data}, {24'h0, exp});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [3:0] o, input logic [AW-1:0] d, input logic [AW-1:0] s,
                       input logic sel, input logic [7:0] i);
    op = o; rd = d; rs = s; imm_sel = sel; imm = i;
    instr_valid = 1'b1;
  endtask

  // Full instruction from IDLE; returns at IDLE with the write visible.
  task automatic run(input string tag, input logic [3:0] o, input logic [AW-1:0] d,
                     input logic [AW-1:0] s, input logic sel, input logic [7:0] i);
    offer(o, d, s, sel, i);
    step();
    instr_valid = 1'b0;
    step();
    check({tag, "_done"}, {31'h0, done}, 32'h1);
    step();
  endtask

  initial begin
    reset = 1'b1; instr_valid = 1'b0; op = '0; rd = '0; rs = '0;
    imm_sel = 1'b0; imm = '0; dbg_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'h0, instr_ready}, 32'h1);
    check("rst_alu_en", {31'h0, alu_en}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_err", {31'h0, err}, 32'h0);
    check("rst_flag", {31'h0, flag}, 32'h0);
    check("rst_funct", {28'h0, alu_funct}, 32'h0);
    #2 reset = 1'b0;
    step();
    check("ready_after_release", {31'h0, instr_ready}, 32'h1);
    check_reg("rst_reg1", 3'd1, 8'h00);

    // add reg1 += 5, cycle by cycle
    en0 = en_count;
    offer(ADD, 3'd1, 3'd0, 1'b1, 8'h05);
    check("idle_alu_en", {31'h0, alu_en}, 32'h0);
    step();
    instr_valid = 1'b0;
    check("iss_en", {31'h0, alu_en}, 32'h1);
    check("iss_funct", {28'h0, alu_funct}, 32'h5);
    check("iss_x", {24'h0, alu_x}, 32'h00);
    check("iss_y", {24'h0, alu_y}, 32'h05);
    check("iss_done", {31'h0, done}, 32'h0);
    check("iss_ready", {31'h0, instr_ready}, 32'h0);
    step();
    check("cap_en", {31'h0, alu_en}, 32'h0);
    check("cap_done", {31'h0, done}, 32'h1);
    check("cap_err", {31'h0, err}, 32'h0);
    check("cap_y", {24'h0, alu_y}, 32'h00);
    step();
    check("ret_done", {31'h0, done}, 32'h0);
    check("ret_ready", {31'h0, instr_ready}, 32'h1);
    check("en_pulses", en_count - en0, 32'd1);
    check_reg("add_reg1", 3'd1, 8'h05);

    // modulo wrap
    run("set_ff", ADD, 3'd1, 3'd0, 1'b1, 8'hFA);
    check_reg("reg1_ff", 3'd1, 8'hFF);
    run("wrap", ADD, 3'd1, 3'd0, 1'b1, 8'h02);
    check_reg("wrap_reg1", 3'd1, 8'h01);

    // compare
    run("set_r2", ADD, 3'd2, 3'd0, 1'b1, 8'h10);
    run("set_r3", ADD, 3'd3, 3'd0, 1'b1, 8'h10);
    offer(CMP, 3'd2, 3'd3, 1'b0, 8'h00);
    step();
    instr_valid = 1'b0;
    check("cmp_funct", {28'h0, alu_funct}, 32'h6);
    check("cmp_x", {24'h0, alu_x}, 32'h10);
    check("cmp_y", {24'h0, alu_y}, 32'h10);
    step();
    step();
    check("cmp_flag_set", {31'h0, flag}, 32'h1);
    check_reg("cmp_reg2", 3'd2, 8'h10);
    run("r5", ADD, 3'd5, 3'd0, 1'b1, 8'h01);
    check("flag_hold", {31'h0, flag}, 32'h1);
    check_reg("r5_val", 3'd5, 8'h01);
    run("cmp_imm", CMP, 3'd2, 3'd0, 1'b1, 8'h11);
    check("cmp_flag_clr", {31'h0, flag}, 32'h0);

    // unsupported op
    en0 = en_count;
    offer(BAD, 3'd1, 3'd2, 1'b1, 8'h33);
    step();
    instr_valid = 1'b0;
    check("bad_en", {31'h0, alu_en}, 32'h0);
    check("bad_err", {31'h0, err}, 32'h1);
    check("bad_done", {31'h0, done}, 32'h1);
    check("bad_funct", {28'h0, alu_funct}, 32'h0);
    step();
    check("bad_ready", {31'h0, instr_ready}, 32'h1);
    check("bad_err_clr", {31'h0, err}, 32'h0);
    check("bad_done_clr", {31'h0, done}, 32'h0);
    check("bad_no_en", en_count - en0, 32'd0);
    check_reg("bad_reg1", 3'd1, 8'h01);
    check_reg("bad_reg2", 3'd2, 8'h10);

    // rd == rs uses the pre-write value on both operands
    offer(ADD, 3'd3, 3'd3, 1'b0, 8'h00);
    step();
    instr_valid = 1'b0;
    check("same_x", {24'h0, alu_x}, 32'h10);
    check("same_y", {24'h0, alu_y}, 32'h10);
    step();
    step();
    check_reg("same_reg3", 3'd3, 8'h20);

    // register-operand sub with wrap, then logic/shift ops on reg2
    run("sub", SUB, 3'd2, 3'd3, 1'b0, 8'h00);
    check_reg("sub_reg2", 3'd2, 8'hF0);
    run("and", AND, 3'd2, 3'd0, 1'b1, 8'h3C);
    check_reg("and_reg2", 3'd2, 8'h30);
    run("or", OR, 3'd2, 3'd0, 1'b1, 8'h05);
    check_reg("or_reg2", 3'd2, 8'h35);
    run("xor", XOR, 3'd2, 3'd0, 1'b1, 8'hFF);
    check_reg("xor_reg2", 3'd2, 8'hCA);
    run("shl", SHL, 3'd2, 3'd0, 1'b1, 8'h01);
    check_reg("shl_reg2", 3'd2, 8'h94);
    run("shr", SHR, 3'd2, 3'd0, 1'b1, 8'h02);
    check_reg("shr_reg2", 3'd2, 8'h25);

    // back-to-back with instr_valid held high; next instruction presented
    // during ISSUE of the previous one must not be latched early
    hs0 = hs_count;
    d0  = done_count;
    offer(ADD, 3'd4, 3'd0, 1'b1, 8'h01);
    step();
    offer(ADD, 3'd4, 3'd0, 1'b1, 8'h02);
    check("b2b_ready_iss", {31'h0, instr_ready}, 32'h0);
    step();
    step();
    check_reg("b2b_reg4_a", 3'd4, 8'h01);
    step();
    offer(SHL, 3'd4, 3'd0, 1'b1, 8'h01);
    step();
    step();
    check_reg("b2b_reg4_b", 3'd4, 8'h03);
    step();
    instr_valid = 1'b0;
    step();
    step();
    check_reg("b2b_reg4_c", 3'd4, 8'h06);
    check("b2b_handshakes", hs_count - hs0, 32'd3);
    check("b2b_dones", done_count - d0, 32'd3);
    n = done_cyc.size();
    if (n >= 3) begin
      check("b2b_spacing", done_cyc[n-1] - done_cyc[n-2], 32'd3);
      check("b2b_span", done_cyc[n-1] - done_cyc[n-3], 32'd6);
    end else begin
      check("b2b_done_log", n, 32'd3);
    end

    // reset during CAPTURE
    run("r4_7", ADD, 3'd4, 3'd0, 1'b1, 8'h01);
    check_reg("r4_7_val", 3'd4, 8'h07);
    d0 = done_count;
    offer(ADD, 3'd4, 3'd0, 1'b1, 8'h05);
    step();
    instr_valid = 1'b0;
    step();
    reset = 1'b1;
    #1;
    check("rc_done", {31'h0, done}, 32'h0);
    check("rc_ready", {31'h0, instr_ready}, 32'h1);
    check_reg("rc_reg4", 3'd4, 8'h00);
    #3 reset = 1'b0;
    step();
    check("rc_ready_after", {31'h0, instr_ready}, 32'h1);
    check("rc_no_done", done_count - d0, 32'd0);
    check("rc_flag", {31'h0, flag}, 32'h0);
    check_reg("rc_reg4_after", 3'd4, 8'h00);
    check_reg("rc_reg1_after", 3'd1, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
